ecc_uop_sequencer: RTL and testbench

Parametrised micro-op sequencer for the ECC engine: accepts a command index, walks the corresponding microcode subroutine in the program ROM and issues each instruction to the datapath with a valid/ready handshake. Long operations (point multiply, HMAC-DRBG, scalar SCA) stall sequencing until the engine signals completion. Subroutine start/end addresses, field widths and command-slot count are parameters and ports, not hard-coded constants. This lets one sequencer serve DSA, DH and future command sets.

---
 rtl/ecc_uop_sequencer.sv | 145 ++++++++++++++
 tb/tb_ecc_uop_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_uop_sequencer.sv
// rtl/ecc_uop_sequencer.sv - ECC engine micro-op sequencer
//
// Purpose: takes a command slot index and walks that slot's microcode
// subroutine [subr_start, subr_end] in the program ROM. Each instruction goes
// to the datapath over a valid/ready handshake. Long instructions stall the
// sequencer until the engine pulses engine_done.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   zeroize           synchronous clear to the reset state (highest priority)
//   cmd_valid/cmd_id  command request / slot index; cmd_ready high in IDLE
//   subr_start/end    packed per-slot start and inclusive end ROM addresses
//   abort             terminate the running subroutine (ignored in IDLE)
//   prog_addr         ROM address (= pc)
//   prog_instr        ROM data, one cycle after prog_addr
//   issue_valid/issue_instr/issue_ready  instruction handshake to the datapath
//   engine_done       single-cycle pulse that ends a long instruction
//   busy, done, err   status: not IDLE / subroutine completed / command rejected
module ecc_uop_sequencer #(
   parameter int                  UOP_W       = 9,
   parameter int                  OPR_W       = 6,
   parameter int                  PROG_ADDR_W = 7,
   parameter int                  NUM_CMD     = 8,
   parameter logic [UOP_W-1:0]    LONG_MASK   = 9'h03F,
   localparam int                 CMD_W       = $clog2(NUM_CMD),
   localparam int                 INSTR_W     = UOP_W + 2*OPR_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           zeroize,
   input  logic                           cmd_valid,
   input  logic [CMD_W-1:0]               cmd_id,
   output logic                           cmd_ready,
   input  logic [NUM_CMD*PROG_ADDR_W-1:0] subr_start,
   input  logic [NUM_CMD*PROG_ADDR_W-1:0] subr_end,
   input  logic                           abort,
   output logic [PROG_ADDR_W-1:0]         prog_addr,
   input  logic [INSTR_W-1:0]             prog_instr,
   output logic                           issue_valid,
   output logic [INSTR_W-1:0]             issue_instr,
   input  logic                           issue_ready,
   input  logic                           engine_done,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [CMD_W:0] NUM_CMD_L = (CMD_W+1)'(NUM_CMD);

   state_t                 r_state;
   logic [PROG_ADDR_W-1:0] r_pc;
   logic [PROG_ADDR_W-1:0] r_end;
   logic                   r_err;

   logic [UOP_W-1:0]       w_opcode;
   logic                   w_is_nop;
   logic                   w_is_long;
   logic                   w_id_bad;
   logic [PROG_ADDR_W-1:0] w_start;
   logic [PROG_ADDR_W-1:0] w_end;
   logic                   w_advance;

   assign w_opcode  = prog_instr[INSTR_W-1 -: UOP_W];
   assign w_is_nop  = (w_opcode == '0);
   assign w_is_long = |(w_opcode & LONG_MASK);

   // Slot lookup is only used when the index is in range (w_id_bad guards it).
   assign w_id_bad  = ({1'b0, cmd_id} >= NUM_CMD_L);
   assign w_start   = subr_start[cmd_id*PROG_ADDR_W +: PROG_ADDR_W];
   assign w_end     = subr_end[cmd_id*PROG_ADDR_W +: PROG_ADDR_W];

   // ROM data only arrives in ISSUE, so the NOP decision (and therefore
   // issue_valid) has to come from the live ROM output rather than a register.
   assign issue_valid = (r_state == ISSUE) && !w_is_nop;
   assign issue_instr = issue_valid ? prog_instr : '0;

   // Move to the next instruction: NOPs and accepted short ops in ISSUE,
   // or a long op completing in WAIT.
   assign w_advance = ((r_state == ISSUE) &&
                       (w_is_nop || (issue_ready && !w_is_long))) ||
                      ((r_state == WAIT) && engine_done);

   assign prog_addr = r_pc;
   assign cmd_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);
   assign err       = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_end   <= '0;
         r_err   <= 1'b0;
      end else if (zeroize) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_end   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (abort && (r_state != IDLE)) begin
            // pc is left alone so the aborted address remains visible.
            r_state <= IDLE;
         end else if (w_advance) begin
            if (r_pc == r_end) begin
               r_state <= DONE;
            end else begin
               r_pc    <= r_pc + 1'b1;
               r_state <= FETCH;
            end
         end else begin
            case (r_state)
               IDLE: begin
                  if (cmd_valid) begin
                     if (w_id_bad || (w_start > w_end)) begin
                        r_err <= 1'b1;
                     end else begin
                        r_pc    <= w_start;
                        r_end   <= w_end;
                        r_state <= FETCH;
                     end
                  end
               end
               FETCH: r_state <= ISSUE;
               ISSUE: begin
                  if (issue_valid && issue_ready) r_state <= WAIT;
               end
               WAIT:  r_state <= WAIT;
               DONE:  r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ecc_uop_sequencer.sv
// tb/tb_ecc_uop_sequencer.sv - self-checking bench for ecc_uop_sequencer
module tb_ecc_uop_sequencer;

   localparam int PAW = 7;
   localparam int IW  = 21;
   localparam int NC  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              zeroize = 1'b0;
   logic              cmd_valid = 1'b0;
   logic [2:0]        cmd_id = '0;
   logic              cmd_ready;
   logic [NC*PAW-1:0] subr_start = '0;
   logic [NC*PAW-1:0] subr_end = '0;
   logic              abort = 1'b0;
   logic [PAW-1:0]    prog_addr;
   logic [IW-1:0]     prog_instr = '0;
   logic              issue_valid;
   logic [IW-1:0]     issue_instr;
   logic              issue_ready = 1'b1;
   logic              engine_done = 1'b0;
   logic              busy, done, err;

   logic [IW-1:0]     rom [128];

   ecc_uop_sequencer dut (
      .clk(clk), .rst(rst), .zeroize(zeroize),
      .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_ready(cmd_ready),
      .subr_start(subr_start), .subr_end(subr_end), .abort(abort),
      .prog_addr(prog_addr), .prog_instr(prog_instr),
      .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
      .engine_done(engine_done), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) prog_instr <= rom[prog_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_slot(input int k, input int s, input int e);
      subr_start[k*PAW +: PAW] = PAW'(s);
      subr_end[k*PAW +: PAW]   = PAW'(e);
   endtask

   // Issues one command at cycle 0 and records what happens until cmd_ready
   // returns after done/err. Outputs are sampled at the falling edge.
   task automatic run_cmd(input int id, input int stall_addr, input int stall_len,
                          input int edone_cyc,
                          output int n_iss, output int done_cyc, output int err_cyc,
                          output int end_cyc, output int busy_seen,
                          output int first_a, output int last_a, output int bad);
      int             stall_cnt;
      logic [IW-1:0]  held_instr;
      logic [PAW-1:0] held_addr;
      n_iss = 0; done_cyc = -1; err_cyc = -1; end_cyc = -1; busy_seen = 0;
      first_a = -1; last_a = -1; bad = 0; stall_cnt = 0;
      held_instr = '0; held_addr = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         cmd_id      = 3'(id);
         cmd_valid   = (cyc == 0);
         engine_done = (cyc == edone_cyc);
         issue_ready = 1'b1;
         if (busy) busy_seen = 1;
         if (done) done_cyc = cyc;
         if (err)  err_cyc  = cyc;
         if (issue_valid) begin
            if (issue_instr !== rom[prog_addr]) bad++;
            if (int'(prog_addr) == stall_addr && stall_cnt < stall_len) begin
               if (stall_cnt == 0) begin
                  held_instr = issue_instr;
                  held_addr  = prog_addr;
               end else if (issue_instr !== held_instr || prog_addr !== held_addr) begin
                  bad++;
               end
               issue_ready = 1'b0;
               stall_cnt++;
            end else begin
               n_iss++;
               if (first_a < 0) first_a = int'(prog_addr);
               last_a = int'(prog_addr);
            end
         end
         if (cyc > 0 && cmd_ready && (done_cyc >= 0 || err_cyc >= 0)) begin
            end_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0; engine_done = 1'b0; issue_ready = 1'b1;
   endtask

   typedef struct {
      string name;
      int id, stall_addr, stall_len, edone;
      int exp_iss, exp_done, exp_err, exp_end, exp_busy, exp_first, exp_last;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int n_iss, done_cyc, err_cyc, end_cyc, busy_seen, first_a, last_a, bad;
      int done_cnt;
      logic [6:0] av;

      for (int a = 0; a < 128; a++) begin
         av = 7'(a);
         rom[a] = {3'b100 | av[2:0], 6'b0, 6'(a), 6'(a) ^ 6'h2A};
      end
      rom[20] = {9'h004, 6'h05, 6'h14};
      rom[26] = {9'h000, 6'h11, 6'h22};

      set_slot(0, 5, 5);
      set_slot(1, 30, 29);
      set_slot(2, 14, 17);
      set_slot(3, 24, 27);
      set_slot(4, 20, 20);
      set_slot(5, 40, 40);
      set_slot(6, 0, 0);
      set_slot(7, 120, 127);

      //        name          id stA stL edn  iss done err end busy first last
      vecs[0] = '{"slot2_4short", 2, -1, 0, 3,   4,  9, -1, 10, 1, 14, 17};
      vecs[1] = '{"slot1_badrng", 1, -1, 0, -1,  0, -1,  1,  1, 0, -1, -1};
      vecs[2] = '{"slot0_single", 0, -1, 0, -1,  1,  3, -1,  4, 1,  5,  5};
      vecs[3] = '{"slot3_nop",    3, -1, 0, -1,  3,  9, -1, 10, 1, 24, 27};
      vecs[4] = '{"slot2_stall",  2, 15, 5, -1,  4, 14, -1, 15, 1, 14, 17};
      vecs[5] = '{"slot4_long",   4, -1, 0, 60,  1, 61, -1, 62, 1, 20, 20};
      vecs[6] = '{"slot6_addr0",  6, -1, 0, -1,  1,  3, -1,  4, 1,  0,  0};
      vecs[7] = '{"slot7_top",    7, -1, 0, -1,  8, 17, -1, 18, 1, 120, 127};

      // Reset values, applied asynchronously.
      #1 rst = 1'b1;
      #1;
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_prog_addr", int'(prog_addr), 0);
      chk("rst_issue_valid", int'(issue_valid), 0);
      chk("rst_done_err", int'({done, err}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_cmd(vecs[i].id, vecs[i].stall_addr, vecs[i].stall_len, vecs[i].edone,
                 n_iss, done_cyc, err_cyc, end_cyc, busy_seen, first_a, last_a, bad);
         chk({vecs[i].name, "_issues"}, n_iss, vecs[i].exp_iss);
         chk({vecs[i].name, "_done_cyc"}, done_cyc, vecs[i].exp_done);
         chk({vecs[i].name, "_err_cyc"}, err_cyc, vecs[i].exp_err);
         chk({vecs[i].name, "_ready_cyc"}, end_cyc, vecs[i].exp_end);
         chk({vecs[i].name, "_busy"}, busy_seen, vecs[i].exp_busy);
         chk({vecs[i].name, "_first_addr"}, first_a, vecs[i].exp_first);
         chk({vecs[i].name, "_last_addr"}, last_a, vecs[i].exp_last);
         chk({vecs[i].name, "_instr_bad"}, bad, 0);
         @(negedge clk);
      end

      // abort in IDLE is ignored
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_ready", int'(cmd_ready), 1);
      chk("idle_abort_busy", int'(busy), 0);

      // abort during WAIT with a coincident engine_done: abort wins, no done
      cmd_id = 3'd4; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("wait_busy", int'(busy), 1);
      abort = 1'b1; engine_done = 1'b1;
      @(negedge clk);
      abort = 1'b0; engine_done = 1'b0;
      done_cnt = int'(done);
      chk("abort_ready", int'(cmd_ready), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_pc_kept", int'(prog_addr), 20);
      repeat (3) begin
         @(negedge clk);
         done_cnt += int'(done);
      end
      chk("abort_no_done", done_cnt, 0);

      // rst while ISSUE is stalled on the second command
      cmd_id = 3'd2; cmd_valid = 1'b1; issue_ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_issue_valid", int'(issue_valid), 1);
      chk("pre_rst_addr", int'(prog_addr), 14);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_issue_valid", int'(issue_valid), 0);
      chk("async_rst_addr", int'(prog_addr), 0);
      chk("async_rst_ready", int'(cmd_ready), 1);
      chk("async_rst_busy_done_err", int'({busy, done, err}), 0);
      @(negedge clk);
      rst = 1'b0; issue_ready = 1'b1;
      @(negedge clk);

      // zeroize mid-subroutine
      cmd_id = 3'd7; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_zero_busy", int'(busy), 1);
      zeroize = 1'b1; abort = 1'b1;
      @(negedge clk);
      zeroize = 1'b0; abort = 1'b0;
      chk("zero_ready", int'(cmd_ready), 1);
      chk("zero_addr", int'(prog_addr), 0);
      chk("zero_issue_valid", int'(issue_valid), 0);
      chk("zero_done_err", int'({done, err}), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
